// File: rtl/xpm_fifo_sync.sv
// rtl/xpm_fifo_sync.sv - single-clock parametrised FIFO with std/fwft read modes
//
// Purpose: common-clock FIFO with occupancy counts, almost/programmable
// thresholds, overflow/underflow/ack/valid status and reset-busy handshakes.
// Ports:
//   wr_clk, rst                       sole clock, synchronous active-high reset
//   wr_en, din                        write request and data
//   full, almost_full, prog_full      write-side flags (registered)
//   wr_data_count, rd_data_count      occupancy, including the fwft output word
//   wr_ack, overflow                  write status pulses
//   rd_en, dout                       read request / pop and read data
//   empty, almost_empty, prog_empty   read-side flags (registered)
//   data_valid, underflow             read status
//   wr_rst_busy, rd_rst_busy          reset in progress
module xpm_fifo_sync #(
   parameter int                         FIFO_WRITE_DEPTH    = 16,
   parameter int                         WRITE_DATA_WIDTH    = 32,
   parameter int                         READ_DATA_WIDTH     = 32,
   parameter string                      READ_MODE           = "std",
   parameter int                         PROG_FULL_THRESH    = 12,
   parameter int                         PROG_EMPTY_THRESH   = 4,
   parameter int                         WR_DATA_COUNT_WIDTH = 5,
   parameter int                         RD_DATA_COUNT_WIDTH = 5,
   parameter logic [READ_DATA_WIDTH-1:0] DOUT_RESET_VALUE    = '0
) (
   input  logic                           wr_clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [WRITE_DATA_WIDTH-1:0]    din,
   output logic                           full,
   output logic                           almost_full,
   output logic                           prog_full,
   output logic [WR_DATA_COUNT_WIDTH-1:0] wr_data_count,
   output logic                           wr_ack,
   output logic                           overflow,
   output logic                           wr_rst_busy,
   input  logic                           rd_en,
   output logic [READ_DATA_WIDTH-1:0]     dout,
   output logic                           empty,
   output logic                           almost_empty,
   output logic                           prog_empty,
   output logic [RD_DATA_COUNT_WIDTH-1:0] rd_data_count,
   output logic                           data_valid,
   output logic                           underflow,
   output logic                           rd_rst_busy
);

   localparam int AW = $clog2(FIFO_WRITE_DEPTH);
   localparam int CW = AW + 1;
   localparam bit FWFT = (READ_MODE == "fwft");
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_WRITE_DEPTH);
   localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
   localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

   if (READ_DATA_WIDTH != WRITE_DATA_WIDTH) begin : g_bad_width
      $error("xpm_fifo_sync: READ_DATA_WIDTH must equal WRITE_DATA_WIDTH");
   end
   if ((1 << AW) != FIFO_WRITE_DEPTH || FIFO_WRITE_DEPTH < 4) begin : g_bad_depth
      $error("xpm_fifo_sync: FIFO_WRITE_DEPTH must be a power of two >= 4");
   end
   if (WR_DATA_COUNT_WIDTH < CW || RD_DATA_COUNT_WIDTH < CW) begin : g_bad_count
      $error("xpm_fifo_sync: data count widths too narrow");
   end

   logic [WRITE_DATA_WIDTH-1:0] mem_q [FIFO_WRITE_DEPTH];

   logic [CW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_q, occ_d;
   logic [1:0]                 busy_cnt_q, busy_cnt_d;
   logic                       out_valid_q, out_valid_d;
   logic [READ_DATA_WIDTH-1:0] dout_q, dout_d;
   logic full_q, full_d, afull_q, afull_d, pfull_q, pfull_d;
   logic empty_q, empty_d, aempty_q, aempty_d, pempty_q, pempty_d;
   logic ack_q, ack_d, ovf_q, ovf_d, udf_q, udf_d, dv_q, dv_d;
   logic busy, busy_d, wr_acc, rd_acc;

   assign busy = (busy_cnt_q != 2'd0);

   always_comb begin
      wr_acc      = wr_en && !full_q && !busy;
      rd_acc      = rd_en && !empty_q && !busy;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      busy_cnt_d  = busy ? busy_cnt_q - 2'd1 : busy_cnt_q;
      ack_d       = wr_acc;
      ovf_d       = wr_en && full_q && !busy;
      udf_d       = rd_en && empty_q && !busy;
      dv_d        = 1'b0;

      if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);

      if (FWFT) begin
         // Prefetch the array head whenever the output register is free or
         // being popped this edge; otherwise a pop just invalidates it.
         if ((!out_valid_q || rd_acc) && (wr_ptr_q != rd_ptr_q)) begin
            dout_d      = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d    = rd_ptr_q + CW'(1);
            out_valid_d = 1'b1;
         end else if (rd_acc) begin
            out_valid_d = 1'b0;
         end
      end else if (rd_acc) begin
         dout_d   = mem_q[rd_ptr_q[AW-1:0]];
         rd_ptr_d = rd_ptr_q + CW'(1);
         dv_d     = 1'b1;
      end

      // The output register counts as held, so only accepted transfers move occupancy.
      occ_d = occ_q + CW'(wr_acc) - CW'(rd_acc);

      if (rst) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         occ_d       = '0;
         out_valid_d = 1'b0;
         dout_d      = DOUT_RESET_VALUE;
         busy_cnt_d  = 2'd2;
         ack_d       = 1'b0;
         ovf_d       = 1'b0;
         udf_d       = 1'b0;
         dv_d        = 1'b0;
      end

      busy_d   = (busy_cnt_d != 2'd0);
      full_d   = busy_d || (occ_d == DEPTH_C);
      afull_d  = (occ_d >= DEPTH_C - CW'(1));
      pfull_d  = (occ_d >= PF_C);
      empty_d  = busy_d || (FWFT ? !out_valid_d : (occ_d == '0));
      aempty_d = (occ_d <= CW'(1));
      pempty_d = (occ_d <= PE_C);
      if (FWFT) dv_d = out_valid_d && !busy_d;
   end

   always_ff @(posedge wr_clk) begin
      if (wr_acc && !rst) mem_q[wr_ptr_q[AW-1:0]] <= din;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      busy_cnt_q  <= busy_cnt_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      pfull_q     <= pfull_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      pempty_q    <= pempty_d;
      ack_q       <= ack_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      dv_q        <= dv_d;
   end

   assign full          = full_q;
   assign almost_full   = afull_q;
   assign prog_full     = pfull_q;
   assign wr_data_count = WR_DATA_COUNT_WIDTH'(occ_q);
   assign rd_data_count = RD_DATA_COUNT_WIDTH'(occ_q);
   assign wr_ack        = ack_q;
   assign overflow      = ovf_q;
   assign wr_rst_busy   = busy;
   assign rd_rst_busy   = busy;
   assign dout          = dout_q;
   assign empty         = empty_q;
   assign almost_empty  = aempty_q;
   assign prog_empty    = pempty_q;
   assign data_valid    = dv_q;
   assign underflow     = udf_q;

endmodule
